// File: rtl/gpio_pattern_check.sv
// gpio_pattern_check
// Receive side of the GPIO counter pattern link. A free-running binary count
// arrives on gpio_in. It is synchronized, filtered for bit skew, and checked
// for +1 increments modulo 2^WIDTH. Lock, error and activity status are
// reported on status ports and on the 8 user LEDs.
//
// Pipeline from a gpio_in change to a status update:
//   edge 1      s1 captures gpio_in
//   edge 2      s2 captures s1
//   edge 3      cand/stab start tracking the new value (stab = 1)
//   edge 2+N    stab reaches STABLE, accept pulse registered
//   edge 3+N    checker state and counters update
// With STABLE = 1, a source that changes every clock is accepted every clock.
//
// locked is a registered copy of "state is LOCKED", so it follows the state
// register by one clock. Counters and err_sticky update on the same edge as
// the state transition that causes them.

module gpio_pattern_check #(
    parameter int WIDTH      = 27,
    parameter int STABLE     = 1,
    parameter int LOCK_COUNT = 16,
    parameter int TIMEOUT    = 1048575
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio_in,
    input  logic             clear,
    output logic             locked,
    output logic             err_sticky,
    output logic [15:0]      err_count,
    output logic [31:0]      good_count,
    output logic [7:0]       led
);

    localparam logic [3:0]       STAB_MAX     = 4'(STABLE);
    localparam logic [7:0]       LOCK_MAX     = 8'(LOCK_COUNT);
    localparam logic [23:0]      TIMEOUT_LAST = 24'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] ONE_W        = WIDTH'(1);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Synchronizer stages
    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;

    // Stability filter
    logic [WIDTH-1:0] cand_reg;
    logic [WIDTH-1:0] cand_next;
    logic [3:0]       stab_reg;
    logic [3:0]       stab_next;
    logic             accept_reg;
    logic             accept_next;

    // Checker state
    state_t           state_reg;
    logic [WIDTH-1:0] last_reg;
    logic [7:0]       consec_reg;
    logic [23:0]      timer_reg;

    // Status registers
    logic             locked_reg;
    logic             err_sticky_reg;
    logic [15:0]      err_count_reg;
    logic [31:0]      good_count_reg;

    // Heartbeat
    logic [23:0]      hb_cnt_reg;
    logic             hb_reg;

    // Derived checker terms
    logic [WIDTH-1:0] expect_value;
    logic             good;
    logic             stall;
    logic             lock_err;
    logic             lock_good;
    logic [15:0]      err_base;
    logic [15:0]      err_inc;
    logic [31:0]      good_base;
    logic             sticky_base;

    // Two-flop synchronizer; gpio_in feeds s1 directly with no logic in between
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= gpio_in;
            s2_reg <= s1_reg;
        end
    end

    // Stability filter next-state: restart on any change, otherwise count up to STABLE
    always_comb begin
        cand_next = cand_reg;
        stab_next = stab_reg;
        if (s2_reg != cand_reg) begin
            cand_next = s2_reg;
            stab_next = 4'd1;
        end else if (stab_reg < STAB_MAX) begin
            stab_next = stab_reg + 4'd1;
        end
    end

    // Accept only on the cycle stab arrives at STABLE. With STABLE = 1 that
    // arrival is a fresh value (s2 != cand) while stab is already 1.
    assign accept_next = (stab_next == STAB_MAX) &&
                         ((stab_next != stab_reg) || (s2_reg != cand_reg));

    // Stability filter registers and the registered accept pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            cand_reg   <= '0;
            stab_reg   <= '0;
            accept_reg <= 1'b0;
        end else begin
            cand_reg   <= cand_next;
            stab_reg   <= stab_next;
            accept_reg <= accept_next;
        end
    end

    // Increment check wraps naturally in WIDTH bits, so all-ones -> 0 is good
    assign expect_value = last_reg + ONE_W;
    assign good         = (cand_reg == expect_value);

    // Stall: TIMEOUT consecutive cycles in LOCKED without an accept
    assign stall     = (state_reg == LOCKED) && !accept_reg && (timer_reg == TIMEOUT_LAST);
    assign lock_err  = (state_reg == LOCKED) && ((accept_reg && !good) || stall);
    assign lock_good = (state_reg == LOCKED) && accept_reg && good;

    // clear zeroes the counters first; an error or good accept in the same
    // cycle is then applied on top, so the event is never lost.
    assign err_base    = clear ? 16'd0 : err_count_reg;
    assign good_base   = clear ? 32'd0 : good_count_reg;
    assign sticky_base = clear ? 1'b0  : err_sticky_reg;
    assign err_inc     = (err_base == 16'hFFFF) ? err_base : err_base + 16'd1;

    // Checker FSM with its counters and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ACQUIRE;
            last_reg       <= '0;
            consec_reg     <= '0;
            timer_reg      <= '0;
            locked_reg     <= 1'b0;
            err_sticky_reg <= 1'b0;
            err_count_reg  <= '0;
            good_count_reg <= '0;
        end else begin
            locked_reg     <= (state_reg == LOCKED);
            err_count_reg  <= err_base;
            good_count_reg <= good_base;
            err_sticky_reg <= sticky_base;

            if (accept_reg) begin
                last_reg <= cand_reg;
            end
            if (lock_err) begin
                err_count_reg  <= err_inc;
                err_sticky_reg <= 1'b1;
            end
            if (lock_good) begin
                good_count_reg <= good_base + 32'd1;
            end

            case (state_reg)
                ACQUIRE: begin
                    // First accepted value only seeds last; nothing to compare yet
                    if (accept_reg) begin
                        consec_reg <= '0;
                        state_reg  <= TRACK;
                    end
                end
                TRACK: begin
                    if (accept_reg) begin
                        if (good) begin
                            consec_reg <= consec_reg + 8'd1;
                            if (consec_reg + 8'd1 == LOCK_MAX) begin
                                state_reg <= LOCKED;
                                timer_reg <= '0;
                            end
                        end else begin
                            // Mismatches while not locked just restart the run
                            consec_reg <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (accept_reg) begin
                        if (good) begin
                            timer_reg <= '0;
                        end else begin
                            consec_reg <= '0;
                            state_reg  <= TRACK;
                        end
                    end else if (stall) begin
                        state_reg <= ACQUIRE;
                    end else begin
                        timer_reg <= timer_reg + 24'd1;
                    end
                end
                default: begin
                    state_reg <= ACQUIRE;
                end
            endcase
        end
    end

    // Free-running heartbeat; toggles once per 2^24 clocks, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            hb_cnt_reg <= '0;
            hb_reg     <= 1'b0;
        end else begin
            hb_cnt_reg <= hb_cnt_reg + 24'd1;
            if (hb_cnt_reg == 24'hFF_FFFF) begin
                hb_reg <= ~hb_reg;
            end
        end
    end

    assign locked     = locked_reg;
    assign err_sticky = err_sticky_reg;
    assign err_count  = err_count_reg;
    assign good_count = good_count_reg;

    // LED map: pure wiring of registered bits
    assign led[0] = locked_reg;
    assign led[1] = err_sticky_reg;
    assign led[2] = hb_reg;
    for (genvar gi = 0; gi < 5; gi++) begin : g_led_err
        assign led[3+gi] = err_count_reg[gi];
    end

endmodule

// File: tb/tb_gpio_pattern_check.sv
// Directed bench for gpio_pattern_check.
// dut  : STABLE = 1, LOCK_COUNT = 16, TIMEOUT = 100
// dut3 : STABLE = 3, LOCK_COUNT = 16, TIMEOUT = 100
// Timing for dut: a value driven before edge n reaches the checker at edge
// n+3. The reset value 0 in the filter is accepted right after reset, which
// only seeds ACQUIRE. The first real value then acts as the TRACK start, so
// counting 0,1,2,... locks when value 16 is checked and locked shows one
// edge later, 21 edges after the first value.

module tb_gpio_pattern_check;

    localparam int W = 27;
    localparam logic [W-1:0] WRAP_BASE = 27'h7FFFFE2;  // wraps to 0 at index 30
    localparam logic [W-1:0] GLITCH    = 27'h5A5A5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, clear;
    logic [W-1:0] gpio_in;
    logic         locked, err_sticky;
    logic [15:0]  err_count;
    logic [31:0]  good_count;
    logic [7:0]   led;

    logic         rst3, clear3;
    logic [W-1:0] gpio3;
    logic         locked3, err_sticky3;
    logic [15:0]  err_count3;
    logic [31:0]  good_count3;
    logic [7:0]   led3;

    gpio_pattern_check #(.WIDTH(W), .STABLE(1), .LOCK_COUNT(16), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .gpio_in(gpio_in), .clear(clear),
        .locked(locked), .err_sticky(err_sticky), .err_count(err_count),
        .good_count(good_count), .led(led)
    );

    gpio_pattern_check #(.WIDTH(W), .STABLE(3), .LOCK_COUNT(16), .TIMEOUT(100)) dut3 (
        .clk(clk), .rst(rst3), .gpio_in(gpio3), .clear(clear3),
        .locked(locked3), .err_sticky(err_sticky3), .err_count(err_count3),
        .good_count(good_count3), .led(led3)
    );

    typedef struct {
        logic [W-1:0] gpio;
        logic         clr;
        logic         rstn;
        logic         exp_locked;
        logic         exp_sticky;
        logic [15:0]  exp_err;
        logic [31:0]  exp_good;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare one status snapshot; the heartbeat cannot toggle within this run
    task automatic status(input string name,
                          input logic a_l, input logic a_s, input logic [15:0] a_e,
                          input logic [31:0] a_g, input logic [7:0] a_led,
                          input logic e_l, input logic e_s, input logic [15:0] e_e,
                          input logic [31:0] e_g);
        logic [7:0] e_led;
        e_led = {e_e[4:0], 1'b0, e_s, e_l};
        $display("%s: locked=%b sticky=%b err=%0d good=%0d led=%h", name, a_l, a_s, a_e, a_g, a_led);
        check({name, ".locked"}, 32'(a_l), 32'(e_l));
        check({name, ".sticky"}, 32'(a_s), 32'(e_s));
        check({name, ".err"},    32'(a_e), 32'(e_e));
        check({name, ".good"},   a_g,      e_g);
        check({name, ".led"},    32'(a_led), 32'(e_led));
    endtask

    task automatic st(input string name, input logic e_l, input logic e_s,
                      input logic [15:0] e_e, input logic [31:0] e_g);
        status(name, locked, err_sticky, err_count, good_count, led, e_l, e_s, e_e, e_g);
    endtask

    task automatic st3(input string name, input logic e_l, input logic e_s,
                       input logic [15:0] e_e, input logic [31:0] e_g);
        status(name, locked3, err_sticky3, err_count3, good_count3, led3, e_l, e_s, e_e, e_g);
    endtask

    task automatic step(input logic [W-1:0] v, input logic clr);
        gpio_in = v;
        clear   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic [W-1:0] v);
        gpio3 = v;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [W-1:0] g, input logic rstn, input logic l,
                       input logic s, input logic [15:0] e, input logic [31:0] gd);
        vec_t r;
        r.gpio = g; r.clr = 1'b0; r.rstn = rstn;
        r.exp_locked = l; r.exp_sticky = s; r.exp_err = e; r.exp_good = gd;
        vecs.push_back(r);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] v;
        logic         lk, er;
        int           gd;

        rst = 1'b0; clear = 1'b0; gpio_in = '0;
        rst3 = 1'b0; clear3 = 1'b0; gpio3 = '0;

        // Wrap run: count through 7FFFFFF -> 0 while locked, no error expected
        add('0, 1'b0, 0, 0, 0, 0);
        add('0, 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            v = WRAP_BASE + W'(i);
            add(v, 1'b1, i >= 20, 0, 0, (i >= 20) ? 32'(i - 19) : 32'd0);
        end

        // Main run: reset, count 0..99 with 100 in place of 57.
        // Bad value checked at index 60 (err, sticky), locked drops at 61.
        // 58 mismatches, 59..74 rebuild the run, relock visible at index 78.
        add('0, 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            v  = (i == 57) ? W'(100) : W'(i);
            lk = (i >= 20 && i <= 60) || (i >= 78);
            er = (i >= 60);
            if (i < 20)      gd = 0;
            else if (i < 60) gd = i - 19;
            else if (i < 78) gd = 40;
            else             gd = i - 37;
            add(v, 1'b1, lk, er, {15'd0, er}, 32'(gd));
        end

        foreach (vecs[k]) begin
            rst = vecs[k].rstn;
            step(vecs[k].gpio, vecs[k].clr);
            status($sformatf("vec%0d", k), locked, err_sticky, err_count, good_count, led,
                   vecs[k].exp_locked, vecs[k].exp_sticky, vecs[k].exp_err, vecs[k].exp_good);
        end

        // clear vs error, relock, clear vs good. Value driven at step s is
        // checked at step s+3; bad 5000 at s3 so clear at s6 coincides.
        for (int s = 0; s <= 26; s++) begin
            v = (s < 3) ? W'(100 + s) : W'(5000 + s - 3);
            step(v, (s == 6) || (s == 26));
            if (s == 6)  st("clr_vs_err",  1, 1, 1, 0);
            if (s == 7)  st("err_unlock",  0, 1, 1, 0);
            if (s == 22) st("relock_pre",  0, 1, 1, 0);
            if (s == 23) st("relock",      1, 1, 1, 1);
            if (s == 26) st("clr_vs_good", 1, 0, 0, 1);
        end

        // Freeze at 5023: last accept checked at s29, stall 100 clocks later
        for (int s = 27; s <= 130; s++) begin
            step(W'(5023), 1'b0);
            if (s == 128) st("stall_pre",  1, 0, 0, 4);
            if (s == 129) st("stall",      1, 1, 1, 4);
            if (s == 130) st("stall_drop", 0, 1, 1, 4);
        end

        // Mid-stream reset, then relock timing as in the main run
        rst = 1'b0;
        step('0, 1'b0);
        st("mid_reset", 0, 0, 0, 0);
        rst = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            step(W'(i), 1'b0);
            if (i == 19) st("relock2_pre", 0, 0, 0, 0);
            if (i == 20) st("relock2",     1, 0, 0, 1);
        end

        // STABLE = 3: 4-clock holds with 1-clock glitches between them
        rst3 = 1'b1;
        for (int v3 = 0; v3 <= 24; v3++) begin
            repeat (4) step3(W'(v3));
            if (v3 < 24) step3(GLITCH);
        end
        repeat (6) step3(W'(24));
        st3("st3_glitch", 1, 0, 0, 8);

        // A 2-clock wrong value is filtered; 25 reaches the checker 6 edges later
        step3(W'(999));
        step3(W'(999));
        step3(W'(25));
        repeat (4) step3(W'(25));
        st3("st3_lat_pre", 1, 0, 0, 8);
        step3(W'(25));
        st3("st3_lat", 1, 0, 0, 9);
        repeat (8) step3(W'(25));
        st3("st3_hold", 1, 0, 0, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_pattern_check.md
Name: gpio_pattern_check

Overview:
- Receive-side counterpart of the on-board GPIO counter pattern generator.
- Samples a free-running binary count arriving on GPIO pins through a loopback cable or from a second board. Checks that each new value is the previous value plus one, modulo 2^WIDTH.
- Reports lock and error status on the 8 user LEDs and on status ports. Used for board bring-up and for checking header and cable integrity.

Parameters:
- WIDTH, 27: width of the GPIO pattern bus.
- STABLE, 1: consecutive identical synchronized samples required before a value is accepted (filters bit skew). Range 1..15.
- LOCK_COUNT, 16: consecutive good increments required to declare lock. Range 1..255.
- TIMEOUT, 1048575: cycles without an accepted value, while locked, before a stall error is flagged. Range 1..2^24-1.

Ports:
- clk, input, 1: single system clock. All logic is on the rising edge.
- rst, input, 1: reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- gpio_in, input, WIDTH: asynchronous pattern input.
- clear, input, 1: synchronous pulse. Clears err_count, good_count and err_sticky, and leaves the state unchanged.
- locked, output, 1: high in state LOCKED.
- err_sticky, output, 1: set on any error counted while locked; held until clear or reset.
- err_count, output, 16: saturating count of errors seen while locked.
- good_count, output, 32: wrapping count of good increments seen while locked.
- led, output, 8: led[0] = locked; led[1] = err_sticky; led[2] = heartbeat; led[7:3] = err_count[4:0].

Behaviour:
- Reset (rst low at a clock edge):
  - All registers cleared; state = ACQUIRE.
  - locked = 0, err_sticky = 0, err_count = 0, good_count = 0, led = 8'h00.
  - Synchronizer flops and the candidate register cleared to 0.
  - Reset asserted mid-operation has the same effect on the next edge.
- Synchronizer: gpio_in passes through two flop stages (s1, s2). No other logic sits between gpio_in and s1.
- Stability filter:
  - Register cand and stability counter stab (4 bits).
  - If s2 != cand: cand <= s2, stab <= 1. Otherwise stab increments, saturating at STABLE.
  - An accept event fires in the single cycle in which stab becomes equal to STABLE. A value held longer produces no further accepts.
- Latency: a gpio_in change to a status update takes 3 + STABLE clock edges. For STABLE = 1 this is 4 edges, and a source changing every clock is accepted every clock.
- Register last holds the previously accepted value. On every accept, last <= cand.
  - good = (cand == last + 1), computed in WIDTH bits with wrap, so all-ones to 0 is good.
- State machine:
  - ACQUIRE: the first accept loads last, consec <= 0 and moves to TRACK. No comparison is made.
  - TRACK:
    - Accept with good: consec++. When consec reaches LOCK_COUNT, move to LOCKED and clear the timeout counter.
    - Accept with not good: consec <= 0 and stay in TRACK. No error is counted.
  - LOCKED:
    - Accept with good: good_count++ (wraps) and the timeout counter is cleared.
    - Accept with not good: err_count++ (saturates at 16'hFFFF), err_sticky <= 1, consec <= 0, move to TRACK.
    - No accept for TIMEOUT consecutive cycles: stall error (same counter and sticky updates) and move to ACQUIRE.
- clear coincident with an error in the same cycle: the error wins. err_count = 1 and err_sticky = 1 after that edge.
- clear coincident with a good accept: good_count = 1 after that edge.
- Heartbeat: led[2] toggles every 2^24 clocks from a free-running counter. The counter is cleared by reset only.
- led and all status outputs are registered.

Test Plan:
- Reset, then drive gpio_in = 0,1,2,… one value per clock -> locked rises exactly 4 + 1 + LOCK_COUNT edges after the first value. err_count stays 0 and good_count increments by 1 per clock.
- While locked, inject the value 100 in place of the expected 57 -> one cycle later locked = 0, err_count = 1, err_sticky = 1, led[1] = 1. Relock occurs after 16 further good increments.
- Wrap: drive 27'h7FFFFFE, 7FFFFFF, 0, 1 while locked -> no error and good_count +3.
- STABLE = 3: hold each value for 4 clocks, with a 1-cycle glitch to an unrelated value between two holds -> the glitch is never accepted and no error is counted. With STABLE = 3 a 2-cycle hold of a wrong value is also not accepted.
- While locked, freeze gpio_in for TIMEOUT clocks (bench sets TIMEOUT = 100) -> err_count +1 and state ACQUIRE; locked falls on clock 101.
- Pulse clear in the same cycle as an injected error -> err_count = 1 and err_sticky = 1. Assert rst low mid-stream -> all outputs 0 on the next edge; relocking then follows the first scenario.
